// File: rtl/core_sequencer.sv
// core_sequencer: multi-cycle control FSM for the RV32I softcore.
// Steps each instruction through FETCH -> DECODE -> EXEC or MEM/WB, or into TRAP.
// Owns the instruction/data memory handshakes, the bus timeout counter and trap entry.
// Datapath strobes are decoded combinationally from the current state and the
// decoder flags, so a strobe lands in the same cycle as the handshake it answers.
module core_sequencer #(
    parameter int unsigned TIMEOUT = 16,  // cycles a request may wait for ack; 0 disables
    parameter int unsigned CW      = 5    // timeout counter width, 2**CW > TIMEOUT
) (
    input  logic       clk,
    input  logic       resetb,
    // instruction fetch
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       ir_we,
    // decoder flags
    input  logic       dec_regwrite,
    input  logic       dec_jump,
    input  logic       dec_jr,
    input  logic       dec_br,
    input  logic       dec_pc_mepc,
    input  logic       dec_csr,
    input  logic       dec_load,
    input  logic       dec_store,
    input  logic       br_taken,
    input  logic       exc_illegal,
    input  logic       exc_unsupported,
    input  logic       exc_misaligned,
    // interrupt
    input  logic       irq,
    input  logic       irq_en,
    // data memory
    output logic       dmem_req,
    output logic       dmem_we,
    input  logic       dmem_ack,
    // datapath strobes
    output logic       rf_we,
    output logic       pc_we,
    output logic       csr_we,
    output logic [1:0] pc_sel,
    output logic       trap_we,
    output logic       trap_irq,
    output logic [3:0] trap_cause,
    output logic       retire
);

    typedef enum logic [2:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    // mcause codes produced by the sequencer
    localparam logic [3:0] CAUSE_IFETCH_FAULT = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL      = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_MISAL   = 4'd4;
    localparam logic [3:0] CAUSE_LOAD_FAULT   = 4'd5;
    localparam logic [3:0] CAUSE_STORE_MISAL  = 4'd6;
    localparam logic [3:0] CAUSE_STORE_FAULT  = 4'd7;
    localparam logic [3:0] CAUSE_EXT_IRQ      = 4'd11;

    // pc_sel encodings
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_MTVEC  = 2'b10;
    localparam logic [1:0] PC_MEPC   = 2'b11;

    // Timeout is reached when the counter sits on its last allowed value
    // without an ack; with TIMEOUT == 0 the limit can never be reached.
    localparam bit            TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] LIMIT = TO_EN ? CW'(TIMEOUT - 1) : '0;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    cause_q;
    logic          cause_irq_q;
    logic          expired;

    assign expired = TO_EN && (cnt_q == LIMIT);

    // State, wait counter and trap cause registers; the counter only counts
    // inside FETCH/MEM and is zero on every entry to those states.
    // NOTE: sequential state uses non-blocking (<=) assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_RST;
            cnt_q       <= '0;
            cause_q     <= '0;
            cause_irq_q <= 1'b0;
        end else begin
            cnt_q <= '0;
            case (state_q)
                S_RST: state_q <= S_FETCH;

                S_FETCH: begin
                    if (imem_ack) begin
                        state_q <= S_DECODE;
                    end else if (expired) begin
                        state_q     <= S_TRAP;
                        cause_q     <= CAUSE_IFETCH_FAULT;
                        cause_irq_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_DECODE: begin
                    if (irq && irq_en) begin
                        state_q     <= S_TRAP;
                        cause_q     <= CAUSE_EXT_IRQ;
                        cause_irq_q <= 1'b1;
                    end else if (exc_unsupported || exc_illegal) begin
                        state_q     <= S_TRAP;
                        cause_q     <= CAUSE_ILLEGAL;
                        cause_irq_q <= 1'b0;
                    end else if (exc_misaligned) begin
                        state_q     <= S_TRAP;
                        cause_q     <= dec_load ? CAUSE_LOAD_MISAL : CAUSE_STORE_MISAL;
                        cause_irq_q <= 1'b0;
                    end else if (dec_load || dec_store) begin
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: state_q <= S_FETCH;

                S_MEM: begin
                    // an ack in the limit cycle still completes the access
                    if (dmem_ack) begin
                        state_q <= S_WB;
                    end else if (expired) begin
                        state_q     <= S_TRAP;
                        cause_q     <= dec_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
                        cause_irq_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_FETCH;
                default: state_q <= S_RST;
            endcase
        end
    end

    // Output decode: requests and strobes from the current state and inputs.
    // NOTE: every output gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        imem_req   = 1'b0;
        ir_we      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        rf_we      = 1'b0;
        pc_we      = 1'b0;
        csr_we     = 1'b0;
        pc_sel     = PC_PLUS4;
        trap_we    = 1'b0;
        trap_irq   = 1'b0;
        trap_cause = '0;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ack;
            end
            S_EXEC: begin
                rf_we  = dec_regwrite;
                csr_we = dec_csr;
                pc_we  = 1'b1;
                retire = 1'b1;
                if (dec_pc_mepc) begin
                    pc_sel = PC_MEPC;
                end else if (dec_jump || dec_jr || (dec_br && br_taken)) begin
                    pc_sel = PC_TARGET;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_store;
            end
            S_WB: begin
                rf_we  = dec_load;
                pc_we  = 1'b1;
                retire = 1'b1;
            end
            S_TRAP: begin
                trap_we    = 1'b1;
                pc_we      = 1'b1;
                pc_sel     = PC_MTVEC;
                trap_cause = cause_q;
                trap_irq   = cause_irq_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: scoreboard bench for core_sequencer.
// The driver issues one instruction at a time (directed cases, then random),
// pushing the outcome predicted from the sequencing rules into a queue.
// The monitor watches the bus each cycle and, whenever the PC is written,
// pops one prediction and compares the commit/trap strobes and request lengths.
`timescale 1ns/1ps
module tb_core_sequencer;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       resetb;
    logic       imem_req, imem_ack, ir_we;
    logic       dec_regwrite, dec_jump, dec_jr, dec_br, dec_pc_mepc, dec_csr;
    logic       dec_load, dec_store, br_taken;
    logic       exc_illegal, exc_unsupported, exc_misaligned;
    logic       irq, irq_en;
    logic       dmem_req, dmem_we, dmem_ack;
    logic       rf_we, pc_we, csr_we;
    logic [1:0] pc_sel;
    logic       trap_we, trap_irq;
    logic [3:0] trap_cause;
    logic       retire;
    logic [15:0] outs;

    assign outs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, csr_we,
                   pc_sel, trap_we, trap_irq, trap_cause, retire};

    core_sequencer #(.TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clk(clk), .resetb(resetb),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_we(ir_we),
        .dec_regwrite(dec_regwrite), .dec_jump(dec_jump), .dec_jr(dec_jr),
        .dec_br(dec_br), .dec_pc_mepc(dec_pc_mepc), .dec_csr(dec_csr),
        .dec_load(dec_load), .dec_store(dec_store), .br_taken(br_taken),
        .exc_illegal(exc_illegal), .exc_unsupported(exc_unsupported),
        .exc_misaligned(exc_misaligned), .irq(irq), .irq_en(irq_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .rf_we(rf_we), .pc_we(pc_we), .csr_we(csr_we), .pc_sel(pc_sel),
        .trap_we(trap_we), .trap_irq(trap_irq), .trap_cause(trap_cause),
        .retire(retire)
    );

    always #5 clk = ~clk;

    // One instruction as the environment presents it.
    typedef struct {
        int fdelay;    bit ftimeout;
        bit regwrite;  bit jump; bit jr; bit br; bit br_taken; bit pc_mepc; bit csr;
        bit load;      bit store;
        bit ill;       bit unsup; bit mis;
        bit irq;       bit irq_en; bit irq_mid;
        int ddelay;    bit dtimeout;
    } txn_t;

    // Predicted outcome at the cycle the PC is written.
    typedef struct {
        int trap; int cause; int tirq; int rf; int csr; int pc_sel; int retire;
        int ireq; int dreq; int dwe; int irw;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the architectural outcome of one instruction.
    function automatic exp_t model(input txn_t t);
        exp_t e = '{default: 0};
        if (t.ftimeout) begin
            e.trap = 1; e.cause = 1; e.ireq = TIMEOUT; e.pc_sel = 2;
            return e;
        end
        e.ireq = t.fdelay + 1;
        e.irw  = 1;
        if (t.irq && t.irq_en) begin
            e.trap = 1; e.cause = 11; e.tirq = 1;
        end else if (t.ill || t.unsup) begin
            e.trap = 1; e.cause = 2;
        end else if (t.mis) begin
            e.trap = 1; e.cause = t.load ? 4 : 6;
        end else if (t.load || t.store) begin
            e.dwe = int'(t.store);
            if (t.dtimeout) begin
                e.dreq = TIMEOUT; e.trap = 1; e.cause = t.store ? 7 : 5;
            end else begin
                e.dreq = t.ddelay + 1; e.rf = int'(t.load); e.retire = 1;
            end
        end else begin
            e.rf = int'(t.regwrite); e.csr = int'(t.csr); e.retire = 1;
            if (t.pc_mepc) e.pc_sel = 3;
            else if (t.jump || t.jr || (t.br && t.br_taken)) e.pc_sel = 1;
        end
        if (e.trap != 0) e.pc_sel = 2;
        return e;
    endfunction

    function automatic txn_t blank();
        txn_t t = '{default: 0};
        return t;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t = blank();
        int   cls = int'($urandom_range(0, 5));
        t.fdelay   = int'($urandom_range(0, 3));
        t.ftimeout = ($urandom_range(0, 15) == 0);
        t.br_taken = 1'($urandom_range(0, 1));
        case (cls)
            0: t.regwrite = 1'b1;
            1: t.br = 1'b1;
            2: begin t.jump = 1'($urandom_range(0, 1)); t.jr = !t.jump; t.regwrite = 1'b1; end
            3: begin t.load = 1'b1; t.regwrite = 1'b1; end
            4: t.store = 1'b1;
            default: begin
                t.csr = 1'b1; t.regwrite = 1'($urandom_range(0, 1));
                t.pc_mepc = 1'($urandom_range(0, 1));
            end
        endcase
        t.ill      = ($urandom_range(0, 11) == 0);
        t.unsup    = ($urandom_range(0, 11) == 0);
        t.mis      = ($urandom_range(0, 7) == 0);
        t.irq      = ($urandom_range(0, 4) == 0);
        t.irq_en   = 1'($urandom_range(0, 1));
        t.irq_mid  = ($urandom_range(0, 3) == 0);
        t.dtimeout = ($urandom_range(0, 4) == 0);
        t.ddelay   = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 3));
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input txn_t t);
        dec_regwrite = t.regwrite; dec_jump = t.jump; dec_jr = t.jr; dec_br = t.br;
        br_taken = t.br_taken; dec_pc_mepc = t.pc_mepc; dec_csr = t.csr;
        dec_load = t.load; dec_store = t.store;
        exc_illegal = t.ill; exc_unsupported = t.unsup; exc_misaligned = t.mis;
        irq = t.irq; irq_en = t.irq_en;
    endtask

    // Drive one instruction through its handshakes until the DUT is back in FETCH.
    task automatic run_instr(input txn_t t);
        int k;
        int guard;
        sb.push_back(model(t));
        apply(t);
        guard = 0;
        while (!imem_req && guard < 20) begin step(); guard++; end
        if (!imem_req) begin check("fetch_start_bound", 32'(imem_req), 32'd1); return; end
        k = 0;
        do begin
            imem_ack = !t.ftimeout && (k == t.fdelay);
            step();
            imem_ack = 1'b0;
            k++;
        end while (imem_req && k < 100);
        guard = 0;
        while (!imem_req && guard < 60) begin
            if (dmem_req) begin
                k = 0;
                do begin
                    dmem_ack = !t.dtimeout && (k == t.ddelay);
                    if (t.irq_mid && k == 1) begin irq = 1'b1; irq_en = 1'b1; end
                    step();
                    dmem_ack = 1'b0;
                    k++;
                end while (dmem_req && k < 100);
                irq = t.irq; irq_en = t.irq_en;
            end else begin
                step();
            end
            guard++;
        end
        if (!imem_req) check("instr_end_bound", 32'(imem_req), 32'd1);
    endtask

    // Monitor: per-cycle bookkeeping, and a scoreboard pop on every PC write.
    int ireq_cnt = 0, dreq_cnt = 0, dwe_seen = 0, irw_cnt = 0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                ireq_cnt = 0; dreq_cnt = 0; dwe_seen = 0; irw_cnt = 0;
                continue;
            end
            if (imem_req) ireq_cnt++;
            if (ir_we) irw_cnt++;
            if (dmem_req) begin
                dreq_cnt++;
                if (dmem_we) dwe_seen = 1;
            end
            if (!trap_we) check("cause_idle", {27'b0, trap_irq, trap_cause}, 32'd0);
            if (pc_we) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_pc_we", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("trap_we",    32'(trap_we),    32'(e.trap));
                    check("trap_cause", 32'(trap_cause), 32'(e.cause));
                    check("trap_irq",   32'(trap_irq),   32'(e.tirq));
                    check("rf_we",      32'(rf_we),      32'(e.rf));
                    check("csr_we",     32'(csr_we),     32'(e.csr));
                    check("pc_sel",     32'(pc_sel),     32'(e.pc_sel));
                    check("retire",     32'(retire),     32'(e.retire));
                    check("imem_req_cycles", 32'(ireq_cnt), 32'(e.ireq));
                    check("dmem_req_cycles", 32'(dreq_cnt), 32'(e.dreq));
                    check("dmem_we",    32'(dwe_seen),   32'(e.dwe));
                    check("ir_we_count", 32'(irw_cnt),   32'(e.irw));
                end
                ireq_cnt = 0; dreq_cnt = 0; dwe_seen = 0; irw_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        resetb = 1'b0;
        apply(blank());
        // acks held high during reset must not leak into any output
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("reset_outputs", 32'(outs), 32'd0);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        @(negedge clk);
        resetb = 1'b1;
        #1;
        check("rst_state_no_req", 32'(imem_req), 32'd0);

        // ADDI, fetch ack on the third request cycle
        t = blank(); t.regwrite = 1'b1; t.fdelay = 2; run_instr(t);
        // BEQ taken / not taken
        t = blank(); t.br = 1'b1; t.br_taken = 1'b1; run_instr(t);
        t = blank(); t.br = 1'b1; t.br_taken = 1'b0; run_instr(t);
        // LW / SW acked three cycles after MEM entry
        t = blank(); t.load = 1'b1; t.regwrite = 1'b1; t.ddelay = 3; run_instr(t);
        t = blank(); t.store = 1'b1; t.ddelay = 3; run_instr(t);
        // store timeout, then ack in the limit cycle
        t = blank(); t.store = 1'b1; t.dtimeout = 1'b1; run_instr(t);
        t = blank(); t.store = 1'b1; t.ddelay = TIMEOUT - 1; run_instr(t);
        t = blank(); t.load = 1'b1; t.dtimeout = 1'b1; run_instr(t);
        // interrupt beats illegal; masked interrupt leaves the illegal trap
        t = blank(); t.irq = 1'b1; t.irq_en = 1'b1; t.ill = 1'b1; run_instr(t);
        t = blank(); t.irq = 1'b1; t.irq_en = 1'b0; t.ill = 1'b1; run_instr(t);
        // misaligned load/store, fetch timeout, mret
        t = blank(); t.load = 1'b1; t.mis = 1'b1; run_instr(t);
        t = blank(); t.store = 1'b1; t.mis = 1'b1; run_instr(t);
        t = blank(); t.ftimeout = 1'b1; run_instr(t);
        t = blank(); t.pc_mepc = 1'b1; t.jump = 1'b1; t.csr = 1'b1; run_instr(t);
        // interrupt raised mid-MEM is not taken by that instruction
        t = blank(); t.load = 1'b1; t.ddelay = 3; t.irq_mid = 1'b1; run_instr(t);

        for (int i = 0; i < 250; i++) begin
            t = rand_txn();
            run_instr(t);
        end

        // Reset while a store waits in MEM
        apply(blank());
        dec_store = 1'b1;
        begin
            int guard = 0;
            while (!imem_req && guard < 20) begin step(); guard++; end
        end
        imem_ack = 1'b1; step(); imem_ack = 1'b0;
        step();
        check("mem_before_reset", 32'({dmem_req, dmem_we}), 32'd3);
        repeat (3) step();
        #2;
        resetb = 1'b0;
        #1;
        check("reset_mid_mem_outputs", 32'(outs), 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetb = 1'b1;
        #1;
        check("rst_after_abort", 32'(imem_req), 32'd0);
        step();
        check("fetch_after_rst", 32'(imem_req), 32'd1);
        // a fetch timeout right after reset shows the counter restarted at 0
        t = blank(); t.ftimeout = 1'b1; run_instr(t);
        t = blank(); t.regwrite = 1'b1; run_instr(t);

        repeat (3) step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
